// File: rtl/pwm_motor_multi.sv
// Multi-channel H-bridge PWM generator: one shared period timer, per-channel
// duty slew limiting, dead-timed direction reversal and brake override.
module pwm_motor_multi #(
  parameter int          NUM_CH       = 4,
  parameter int          DC_Precision = 8,
  parameter int          Period       = 18,
  parameter int unsigned RAMP_STEP    = 8,
  parameter int          DEAD_PERIODS = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_CH-1:0]              fb,
  input  logic [NUM_CH-1:0]              brake,
  input  logic [NUM_CH*DC_Precision-1:0] DutyCycleIn,
  output logic [2*NUM_CH-1:0]            MotorOut,
  output logic [NUM_CH-1:0]              busy,
  output logic                           period_start
);

  localparam int DW = $clog2(DEAD_PERIODS + 1);

  typedef enum logic [1:0] {RUN, DRAIN, DEAD, BRAKE} state_t;

  logic [Period-1:0]       timer;
  logic                    zero;
  state_t                  state    [NUM_CH];
  state_t                  state_nx [NUM_CH];
  logic [DC_Precision-1:0] act      [NUM_CH];
  logic [DC_Precision-1:0] act_nx   [NUM_CH];
  logic [DW-1:0]           dead     [NUM_CH];
  logic [DW-1:0]           dead_nx  [NUM_CH];
  logic [1:0]              mout     [NUM_CH];
  logic [1:0]              mout_nx  [NUM_CH];
  logic [NUM_CH-1:0]       dir;
  logic [NUM_CH-1:0]       dir_nx;

  assign zero = (timer == '0);

  // Saturating step of at most RAMP_STEP from cur toward tgt.
  function automatic logic [DC_Precision-1:0] ramp(
    input logic [DC_Precision-1:0] cur,
    input logic [DC_Precision-1:0] tgt
  );
    int unsigned c;
    int unsigned t;
    c = 32'(cur);
    t = 32'(tgt);
    if (RAMP_STEP == 0) return tgt;
    if (t >= c) begin
      if (t - c <= RAMP_STEP) return tgt;
      return DC_Precision'(c + RAMP_STEP);
    end
    if (c - t <= RAMP_STEP) return tgt;
    return DC_Precision'(c - RAMP_STEP);
  endfunction

  always_comb begin
    dir_nx = dir;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      state_nx[ch] = state[ch];
      act_nx[ch]   = act[ch];
      dead_nx[ch]  = dead[ch];
      mout_nx[ch]  = mout[ch];
      if (brake[ch]) begin
        state_nx[ch] = BRAKE;
        act_nx[ch]   = '0;
        mout_nx[ch]  = 2'b11;
      end else if (zero) begin
        unique case (state[ch])
          RUN: begin
            if (fb[ch] == dir[ch]) begin
              act_nx[ch] = ramp(act[ch], DutyCycleIn[ch*DC_Precision +: DC_Precision]);
            end else begin
              state_nx[ch] = DRAIN;
              act_nx[ch]   = ramp(act[ch], '0);
            end
          end
          DRAIN: begin
            act_nx[ch] = ramp(act[ch], '0);
            if (act_nx[ch] == '0) begin
              state_nx[ch] = DEAD;
              dead_nx[ch]  = DW'(DEAD_PERIODS);
            end
          end
          DEAD: begin
            act_nx[ch] = '0;
            if (dead[ch] <= DW'(1)) begin
              state_nx[ch] = RUN;
              dead_nx[ch]  = '0;
              dir_nx[ch]   = fb[ch];
            end else begin
              dead_nx[ch] = dead[ch] - DW'(1);
            end
          end
          BRAKE: begin
            state_nx[ch] = RUN;
            act_nx[ch]   = '0;
            dir_nx[ch]   = fb[ch];
          end
        endcase
        // Direction only changes while act is 0, so the old dir is safe here.
        mout_nx[ch] = (act_nx[ch] != '0) ? (dir[ch] ? 2'b10 : 2'b01) : 2'b00;
      end else if (state[ch] != BRAKE &&
                   timer[Period-1 -: DC_Precision] == act[ch]) begin
        mout_nx[ch] = 2'b00;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer        <= '0;
      period_start <= 1'b0;
      dir          <= '1;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state[ch] <= RUN;
        act[ch]   <= '0;
        dead[ch]  <= '0;
        mout[ch]  <= 2'b00;
      end
    end else begin
      timer        <= timer + Period'(1);
      period_start <= zero;
      dir          <= dir_nx;
      for (int ch = 0; ch < NUM_CH; ch++) begin
        state[ch] <= state_nx[ch];
        act[ch]   <= act_nx[ch];
        dead[ch]  <= dead_nx[ch];
        mout[ch]  <= mout_nx[ch];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign MotorOut[2*g +: 2] = mout[g];
    assign busy[g]            = (state[g] == DRAIN) || (state[g] == DEAD);
  end

endmodule

// File: tb/tb_pwm_motor_multi.sv
// Scoreboard bench for pwm_motor_multi: per-period high/brake cycle counts are
// queued as expectations and compared as each 64-cycle period completes.
module tb_pwm_motor_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] fb = 2'b11;
  logic [1:0] brake = 2'b00;
  logic [7:0] duty = {4'd0, 4'd12};
  logic [3:0] motor;
  logic [1:0] busy;
  logic       period_start;

  logic [1:0] fb2 = 2'b11;
  logic [1:0] brake2 = 2'b00;
  logic [7:0] duty2 = {4'd0, 4'd15};
  logic [3:0] motor2;
  logic [1:0] busy2;
  logic       ps2;

  int vectors = 0;
  int miscompares = 0;
  int trans_viol = 0;
  logic [1:0] prev_mo [2];

  typedef struct packed {
    logic [7:0] hi0;
    logic [1:0] code0;
    logic       busy0;
    logic [7:0] hi1;
    logic [1:0] code1;
    logic [7:0] brk1;
    logic [7:0] hi2;
    logic [7:0] waited;
    logic [7:0] pulses;
  } per_t;

  per_t exp_q[$];

  pwm_motor_multi #(.NUM_CH(2), .DC_Precision(4), .Period(6), .RAMP_STEP(4), .DEAD_PERIODS(2)) dut (
    .clk(clk), .reset(reset), .fb(fb), .brake(brake), .DutyCycleIn(duty),
    .MotorOut(motor), .busy(busy), .period_start(period_start)
  );

  pwm_motor_multi #(.NUM_CH(2), .DC_Precision(4), .Period(6), .RAMP_STEP(0), .DEAD_PERIODS(2)) dut2 (
    .clk(clk), .reset(reset), .fb(fb2), .brake(brake2), .DutyCycleIn(duty2),
    .MotorOut(motor2), .busy(busy2), .period_start(ps2)
  );

  always #5 clk = ~clk;

  // A direct 10 <-> 01 step on any channel is a shoot-through hazard.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if ((prev_mo[c] === 2'b10 && motor[2*c +: 2] === 2'b01) ||
          (prev_mo[c] === 2'b01 && motor[2*c +: 2] === 2'b10))
        trans_viol++;
      prev_mo[c] = motor[2*c +: 2];
    end
  end

  function automatic per_t exp_p(int hi0, logic [1:0] c0, logic b0, int hi1, logic [1:0] c1, int brk1);
    per_t p;
    p.hi0 = 8'(hi0);  p.code0 = c0;  p.busy0 = b0;
    p.hi1 = 8'(hi1);  p.code1 = c1;  p.brk1 = 8'(brk1);
    p.hi2 = 8'd60;    p.waited = 8'd1;  p.pulses = 8'd1;
    return p;
  endfunction

  function automatic string fmt(per_t p);
    return $sformatf("hi0=%0d c0=%b b0=%b hi1=%0d c1=%b brk1=%0d hi2=%0d wait=%0d ps=%0d",
                     p.hi0, p.code0, p.busy0, p.hi1, p.code1, p.brk1, p.hi2, p.waited, p.pulses);
  endfunction

  // Align to the cycle after a Zero edge, then sample one full period.
  task automatic measure(output per_t obs);
    int   waited;
    logic found;
    obs = '0;
    waited = 0;
    found = 1'b0;
    while (!found && waited < 200) begin
      @(negedge clk);
      waited++;
      found = (period_start === 1'b1);
    end
    obs.waited = 8'(waited);
    for (int k = 0; k < 64; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 0) obs.busy0 = busy[0];
      if (period_start === 1'b1) obs.pulses = obs.pulses + 8'd1;
      if (motor[1:0] === 2'b10 || motor[1:0] === 2'b01) begin
        obs.hi0 = obs.hi0 + 8'd1;
        obs.code0 = motor[1:0];
      end
      if (motor[3:2] === 2'b10 || motor[3:2] === 2'b01) begin
        obs.hi1 = obs.hi1 + 8'd1;
        obs.code1 = motor[3:2];
      end
      if (motor[3:2] === 2'b11) obs.brk1 = obs.brk1 + 8'd1;
      if (motor2[1:0] === 2'b10) obs.hi2 = obs.hi2 + 8'd1;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({motor, busy, period_start, motor2} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_state got %b want 0", {motor, busy, period_start, motor2});
    end
    reset = 1'b1;
  endtask

  task automatic test_ramp_up();
    per_t obs;
    per_t exp;
    exp_q.push_back(exp_p(16, 2'b10, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(32, 2'b10, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(48, 2'b10, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(48, 2'b10, 1'b0, 0, 2'b00, 0));
    for (int i = 0; i < 4; i++) begin
      measure(obs);
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL ramp_up p%0d got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_reversal();
    per_t obs;
    per_t exp;
    fb = 2'b10;
    exp_q.push_back(exp_p(32, 2'b10, 1'b1, 0, 2'b00, 0));
    exp_q.push_back(exp_p(16, 2'b10, 1'b1, 0, 2'b00, 0));
    exp_q.push_back(exp_p(0,  2'b00, 1'b1, 0, 2'b00, 0));
    exp_q.push_back(exp_p(0,  2'b00, 1'b1, 0, 2'b00, 0));
    exp_q.push_back(exp_p(0,  2'b00, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(16, 2'b01, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(32, 2'b01, 1'b0, 0, 2'b00, 0));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 0, 2'b00, 0));
    for (int i = 0; i < 8; i++) begin
      measure(obs);
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL reversal p%0d got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
    vectors++;
    if (trans_viol !== 0) begin
      miscompares++;
      $display("[TB] FAIL reversal_adjacent got %0d direct transitions want 0", trans_viol);
    end
  endtask

  task automatic test_brake();
    per_t obs;
    per_t exp;
    duty = {4'd8, 4'd12};
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 16, 2'b10, 0));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 32, 2'b10, 0));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 10, 2'b10, 54));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 0,  2'b00, 64));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 0,  2'b00, 0));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 16, 2'b10, 0));
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 32, 2'b10, 0));
    for (int i = 0; i < 7; i++) begin
      if (i == 2) begin
        fork
          measure(obs);
          begin
            repeat (10) @(negedge clk);
            brake = 2'b10;
            @(negedge clk);
            vectors++;
            if (motor[3:2] !== 2'b11) begin
              miscompares++;
              $display("[TB] FAIL brake_entry got %b want 11", motor[3:2]);
            end
          end
        join
      end else if (i == 3) begin
        fork
          measure(obs);
          begin
            repeat (20) @(negedge clk);
            brake = 2'b00;
          end
        join
      end else begin
        measure(obs);
      end
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL brake p%0d got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_mid_period_change();
    per_t obs;
    per_t exp;
    exp_q.push_back(exp_p(48, 2'b01, 1'b0, 32, 2'b10, 0));
    exp_q.push_back(exp_p(32, 2'b01, 1'b0, 32, 2'b10, 0));
    exp_q.push_back(exp_p(16, 2'b01, 1'b0, 32, 2'b10, 0));
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin
        fork
          measure(obs);
          begin
            repeat (20) @(negedge clk);
            duty = {4'd8, 4'd4};
          end
        join
      end else begin
        measure(obs);
      end
      exp = exp_q.pop_front();
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("[TB] FAIL mid_change p%0d got %s want %s", i, fmt(obs), fmt(exp));
      end
    end
  endtask

  task automatic test_async_reset();
    per_t obs;
    per_t exp;
    fb = 2'b11;
    exp_q.push_back(exp_p(0, 2'b00, 1'b1, 32, 2'b10, 0));
    measure(obs);
    exp = exp_q.pop_front();
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL async_pre_period got %s want %s", fmt(obs), fmt(exp));
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ({busy[0], motor} !== 5'b1_1000) begin
      miscompares++;
      $display("[TB] FAIL async_pre_state got %b want 11000", {busy[0], motor});
    end
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if ({motor, busy, period_start, motor2, busy2, ps2} !== 14'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset got %b want 0", {motor, busy, period_start, motor2, busy2, ps2});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    vectors++;
    if ({period_start, motor} !== 5'b1_1010) begin
      miscompares++;
      $display("[TB] FAIL restart got %b want 11010", {period_start, motor});
    end
    vectors++;
    if (trans_viol !== 0) begin
      miscompares++;
      $display("[TB] FAIL no_adjacent got %0d direct transitions want 0", trans_viol);
    end
  endtask

  initial begin
    test_reset();
    test_ramp_up();
    test_reversal();
    test_brake();
    test_mid_period_change();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
